// File: rtl/bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_transfer_ctrl
// Brief    : Sequences register-to-register moves and single-register
//            increments over a shared bidirectional DATA bus.
// Revision : 1.0  initial release
// ============================================================================
module bus_transfer_ctrl #(
   parameter int NUM_REGS  = 8,
   parameter int SEL_WIDTH = 3
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic                 REQ,
   input  logic [SEL_WIDTH-1:0] SRC,
   input  logic [SEL_WIDTH-1:0] DST,
   input  logic                 INC_REQ,
   input  logic [SEL_WIDTH-1:0] INC_SEL,
   output logic [NUM_REGS-1:0]  EN,
   output logic [NUM_REGS-1:0]  RW,
   output logic [NUM_REGS-1:0]  COUNT,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 ERR
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam logic [SEL_WIDTH:0]  c_num_regs = (SEL_WIDTH+1)'(NUM_REGS);
   localparam logic [NUM_REGS-1:0] c_one      = NUM_REGS'(1);

   state_t               r_state;
   logic [SEL_WIDTH-1:0] r_src;
   logic [SEL_WIDTH-1:0] r_dst;
   logic [NUM_REGS-1:0]  r_en;
   logic [NUM_REGS-1:0]  r_rw;
   logic [NUM_REGS-1:0]  r_count;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;

   state_t               w_state_nxt;
   logic [SEL_WIDTH-1:0] w_src_nxt;
   logic [SEL_WIDTH-1:0] w_dst_nxt;
   logic [NUM_REGS-1:0]  w_en_nxt;
   logic [NUM_REGS-1:0]  w_rw_nxt;
   logic [NUM_REGS-1:0]  w_count_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic                 w_err_nxt;
   logic [NUM_REGS-1:0]  w_src_oh;
   logic [NUM_REGS-1:0]  w_dst_oh;

   logic w_src_ok;
   logic w_dst_ok;
   logic w_inc_ok;

   assign w_src_ok = ({1'b0, SRC}     < c_num_regs);
   assign w_dst_ok = ({1'b0, DST}     < c_num_regs);
   assign w_inc_ok = ({1'b0, INC_SEL} < c_num_regs);

   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_count_nxt = '0;
      w_err_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            // A transfer request always takes priority; a coincident increment is dropped.
            if (REQ) begin
               if (w_src_ok && w_dst_ok && (SRC != DST)) begin
                  w_state_nxt = S_DRIVE;
                  w_src_nxt   = SRC;
                  w_dst_nxt   = DST;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end else if (INC_REQ) begin
               if (w_inc_ok) begin
                  w_count_nxt = c_one << INC_SEL;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_DRIVE:   w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_RELEASE;
         S_RELEASE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase

      // Outputs are decoded from the upcoming state so they register in step with it.
      w_src_oh   = c_one << w_src_nxt;
      w_dst_oh   = c_one << w_dst_nxt;
      w_en_nxt   = '0;
      w_rw_nxt   = '1;
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_RELEASE);
      case (w_state_nxt)
         S_DRIVE: w_en_nxt = w_src_oh;
         S_CAPTURE: begin
            w_en_nxt = w_src_oh | w_dst_oh;
            w_rw_nxt = ~w_dst_oh;
         end
         default: w_en_nxt = '0;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_en    <= '0;
         r_rw    <= '1;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
         r_en    <= w_en_nxt;
         r_rw    <= w_rw_nxt;
         r_count <= w_count_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign EN    = r_en;
   assign RW    = r_rw;
   assign COUNT = r_count;
   assign BUSY  = r_busy;
   assign DONE  = r_done;
   assign ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_ctrl.sv
`default_nettype none
// Testbench for bus_transfer_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a queue of expected output frames.
module tb_bus_transfer_ctrl;
   localparam int NR = 8;
   localparam int SW = 4;

   logic          CLOCK = 1'b0;
   logic          RESET;
   logic          REQ;
   logic          INC_REQ;
   logic [SW-1:0] SRC;
   logic [SW-1:0] DST;
   logic [SW-1:0] INC_SEL;
   logic [NR-1:0] EN;
   logic [NR-1:0] RW;
   logic [NR-1:0] COUNT;
   logic          BUSY;
   logic          DONE;
   logic          ERR;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [NR-1:0] en;
      logic [NR-1:0] rw;
      logic [NR-1:0] cnt;
      logic          busy;
      logic          done;
      logic          err;
   } frame_t;

   frame_t      exp_q[$];
   frame_t      exp_f;
   logic [15:0] regs [NR];

   bus_transfer_ctrl #(.NUM_REGS(NR), .SEL_WIDTH(SW)) dut (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .REQ    (REQ),
      .SRC    (SRC),
      .DST    (DST),
      .INC_REQ(INC_REQ),
      .INC_SEL(INC_SEL),
      .EN     (EN),
      .RW     (RW),
      .COUNT  (COUNT),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .ERR    (ERR)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic frame_t idle_frame();
      frame_t f;
      f.en   = '0;
      f.rw   = '1;
      f.cnt  = '0;
      f.busy = 1'b0;
      f.done = 1'b0;
      f.err  = 1'b0;
      return f;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_frame();
      check("EN",    16'(EN),    16'(exp_f.en));
      check("RW",    16'(RW),    16'(exp_f.rw));
      check("COUNT", 16'(COUNT), 16'(exp_f.cnt));
      check("BUSY",  16'(BUSY),  16'(exp_f.busy));
      check("DONE",  16'(DONE),  16'(exp_f.done));
      check("ERR",   16'(ERR),   16'(exp_f.err));
      check("single_driver", 16'($countones(EN & RW) <= 1), 16'd1);
      check("single_load",   16'($countones(~RW) <= 1),     16'd1);
   endtask

   // Transaction-level model: an accepted request expands into the frames it produces.
   task automatic model_edge(input logic req, input int s, input int d,
                             input logic inc, input int is);
      frame_t f;
      logic [NR-1:0] soh;
      logic [NR-1:0] doh;
      if (exp_q.size() == 0) begin
         if (req) begin
            if (s != d && s < NR && d < NR) begin
               soh = NR'(1) << s;
               doh = NR'(1) << d;
               f = idle_frame(); f.busy = 1'b1; f.en = soh;
               exp_q.push_back(f);
               f = idle_frame(); f.busy = 1'b1; f.en = soh | doh; f.rw = ~doh;
               exp_q.push_back(f);
               f = idle_frame(); f.busy = 1'b1; f.done = 1'b1;
               exp_q.push_back(f);
               exp_q.push_back(idle_frame());
            end else begin
               f = idle_frame(); f.err = 1'b1;
               exp_q.push_back(f);
            end
         end else if (inc) begin
            f = idle_frame();
            if (is < NR) f.cnt = NR'(1) << is;
            else         f.err = 1'b1;
            exp_q.push_back(f);
         end
      end
      if (exp_q.size() == 0) exp_f = idle_frame();
      else                   exp_f = exp_q.pop_front();
   endtask

   // One clock: drive inputs, move register contents per the bus controls, check outputs.
   task automatic step(input logic req, input int s, input int d, input logic inc, input int is);
      logic [NR-1:0] en_s;
      logic [NR-1:0] rw_s;
      logic [NR-1:0] cnt_s;
      logic [15:0]   bus;
      REQ = req; SRC = SW'(s); DST = SW'(d); INC_REQ = inc; INC_SEL = SW'(is);
      en_s = EN; rw_s = RW; cnt_s = COUNT;
      @(posedge CLOCK);
      bus = 16'hxxxx;
      for (int i = 0; i < NR; i++) if (en_s[i] && rw_s[i]) bus = regs[i];
      for (int i = 0; i < NR; i++) begin
         if (en_s[i] && !rw_s[i]) regs[i] = bus;
         if (cnt_s[i])            regs[i] = regs[i] + 16'd1;
      end
      model_edge(req, s, d, inc, is);
      @(negedge CLOCK);
      check_frame();
   endtask

   initial begin
      int dones;
      RESET = 1'b1; REQ = 1'b0; INC_REQ = 1'b0; SRC = '0; DST = '0; INC_SEL = '0;
      for (int i = 0; i < NR; i++) regs[i] = 16'h1000 + 16'(i);
      #1;
      exp_f = idle_frame();
      check_frame();
      @(negedge CLOCK);
      @(negedge CLOCK);
      RESET = 1'b0;

      // Basic transfer reg2 -> reg5
      regs[2] = 16'h1234; regs[5] = 16'h0000;
      step(1'b1, 2, 5, 1'b0, 0);
      for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0, 0);
      check("reg5_loaded", regs[5], 16'h1234);

      // Rejected requests
      step(1'b1, 3, 3, 1'b0, 0);
      step(1'b1, 1, 9, 1'b0, 0);
      step(1'b0, 0, 0, 1'b0, 0);

      // REQ held high: one transfer every 4 cycles
      regs[0] = 16'hA5A5;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         step(1'b1, 0, 1, 1'b0, 0);
         if (DONE === 1'b1) dones++;
      end
      check("held_req_dones", 16'(dones), 16'd3);
      check("reg1_loaded", regs[1], 16'hA5A5);

      // Increment, then REQ+INC together, then out-of-range INC
      regs[4] = 16'h00FF;
      step(1'b0, 0, 0, 1'b1, 4);
      step(1'b0, 0, 0, 1'b0, 0);
      check("reg4_inc", regs[4], 16'h0100);
      regs[6] = 16'h6666; regs[7] = 16'h0007;
      step(1'b1, 6, 7, 1'b1, 4);
      for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0, 0);
      check("reg4_no_inc", regs[4], 16'h0100);
      check("reg7_loaded", regs[7], 16'h6666);
      step(1'b0, 0, 0, 1'b1, 9);
      step(1'b0, 0, 0, 1'b0, 0);

      // Reset in the middle of CAPTURE
      regs[3] = 16'hBEEF; regs[6] = 16'h1006;
      step(1'b1, 3, 6, 1'b0, 0);
      step(1'b0, 0, 0, 1'b0, 0);
      #2 RESET = 1'b1;
      #1;
      exp_q.delete();
      exp_f = idle_frame();
      check_frame();
      #1 RESET = 1'b0;
      check("reg6_not_loaded", regs[6], 16'h1006);
      step(1'b1, 3, 6, 1'b0, 0);
      for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0, 0);
      check("reg6_after_reset", regs[6], 16'hBEEF);

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         step($urandom_range(0, 2) == 0, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
              $urandom_range(0, 2) == 0, int'($urandom_range(0, 9)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/bus_transfer_ctrl.md
BUS_TRANSFER_CTRL -- requirements
Module: bus_transfer_ctrl

Interface
REQ-001 Parameter: NUM_REGS, default 8, number of bidi_register instances on the shared DATA bus.
REQ-002 Parameter: SEL_WIDTH, default 3, width of register index inputs; 2**SEL_WIDTH >= NUM_REGS.
REQ-003 Port: CLOCK  input  1  single clock; all state SHALL update on posedge.
REQ-004 Port: RESET  input  1  asynchronous, active-high reset.
REQ-005 Port: REQ  input  1  transfer request, sampled only in IDLE.
REQ-006 Port: SRC  input  SEL_WIDTH  index of register to drive the bus.
REQ-007 Port: DST  input  SEL_WIDTH  index of register to load from the bus.
REQ-008 Port: INC_REQ  input  1  increment request, sampled only in IDLE.
REQ-009 Port: INC_SEL  input  SEL_WIDTH  index of register to increment.
REQ-010 Port: EN  output  NUM_REGS  per-register ENABLE, one bit per register.
REQ-011 Port: RW  output  NUM_REGS  per-register RW (0 = load from bus, 1 = drive bus/count).
REQ-012 Port: COUNT  output  NUM_REGS  per-register COUNT strobe.
REQ-013 Port: BUSY  output  1  high while a transfer is in progress.
REQ-014 Port: DONE  output  1  one-cycle pulse on transfer completion.
REQ-015 Port: ERR  output  1  one-cycle pulse on rejected request.

Function
REQ-016 FSM states SHALL be IDLE, DRIVE, CAPTURE, RELEASE; all outputs SHALL be registered, decoded from state and the latched indices.
REQ-017 In IDLE, REQ=1 with SRC!=DST and both < NUM_REGS SHALL latch SRC/DST and move to DRIVE at that edge.
REQ-018 In IDLE, REQ=1 with SRC==DST or either index >= NUM_REGS SHALL pulse ERR for one cycle and remain in IDLE.
REQ-019 DRIVE: EN[src]=1, RW[src]=1, all other EN=0; next state CAPTURE unconditionally.
REQ-020 CAPTURE: EN[src]=1, RW[src]=1, EN[dst]=1, RW[dst]=0; next state RELEASE unconditionally.
REQ-021 RELEASE: all EN=0, DONE=1; next state IDLE unconditionally.
REQ-022 Request-to-DONE latency SHALL be exactly 3 cycles; back-to-back transfers SHALL occur every 4 cycles at most.
REQ-023 BUSY SHALL be 1 in DRIVE, CAPTURE, RELEASE and 0 in IDLE.
REQ-024 RW bits not selected as a load target SHALL be 1 in every state; at most one RW bit SHALL be 0 at any time.
REQ-025 At most one EN bit with RW=1 SHALL be asserted in any cycle (single bus driver).
REQ-026 REQ, INC_REQ, SRC, DST, INC_SEL changes outside IDLE SHALL be ignored; latched indices SHALL not change mid-transfer.
REQ-027 In IDLE with REQ=0, INC_REQ=1 and INC_SEL < NUM_REGS SHALL assert COUNT[INC_SEL] for exactly one cycle, with EN all 0 and state remaining IDLE.
REQ-028 INC_REQ with INC_SEL >= NUM_REGS SHALL pulse ERR and assert no COUNT bit.
REQ-029 REQ and INC_REQ asserted together in IDLE: REQ SHALL win; INC_REQ SHALL be dropped, not queued.
REQ-030 COUNT SHALL be 0 in all non-IDLE states.

Reset
REQ-031 RESET=1 SHALL immediately, without a clock edge, force state IDLE, EN=0, RW=all ones, COUNT=0, BUSY=0, DONE=0, ERR=0, and latched indices to 0.
REQ-032 RESET asserted mid-transfer SHALL abort it with no DONE; the destination SHALL not be loaded unless CAPTURE's edge already occurred.
REQ-033 After RESET deasserts, the first REQ SHALL be accepted on the first clock edge.

Verification
REQ-034 Reset, then REQ with SRC=2, DST=5, reg2=0x1234 -> EN=0x04 (1 cycle), EN=0x24 with RW[5]=0 (1 cycle), DONE pulse, reg5=0x1234, BUSY low after 4 cycles.
REQ-035 REQ with SRC=3, DST=3; then SRC=1, DST=9 with NUM_REGS=8 -> ERR pulse each time, EN stays 0, BUSY stays 0.
REQ-036 REQ held high continuously with SRC=0, DST=1 -> transfers every 4 cycles, never two EN&RW drivers, bus Z for at least 1 cycle between transfers.
REQ-037 INC_REQ with INC_SEL=4, reg4=0x00FF -> COUNT=0x10 for 1 cycle, reg4=0x0100; REQ+INC_REQ together -> only the transfer occurs.
REQ-038 RESET asserted during CAPTURE, between edges -> outputs return to idle values asynchronously, no DONE, next REQ accepted normally.
